// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: accepts words over a valid/ready stream and
// serializes them MSB-first onto ccff_head, gating chain shifting with
// chain_shift_en, until exactly CHAIN_LEN bits have been delivered.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              chain_shift_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
);

  // Wide enough to hold WORD_W itself.
  localparam int unsigned WbW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {StIdle, StWait, StShift, StDone} state_e;

  state_e            r_state_q, w_state_d;
  logic [WORD_W-1:0] r_shift_q, w_shift_d;
  logic [CNT_W-1:0]  r_cnt_q,   w_cnt_d;
  logic [WbW-1:0]    r_wbits_q, w_wbits_d;

  logic [31:0]       w_remain;
  logic [WbW-1:0]    w_wbits_load;

  // Bits still owed to the chain; the last word may be only partly shifted.
  assign w_remain = CHAIN_LEN - 32'(r_cnt_q);

  // Clamp the per-word bit budget to what the chain still needs.
  always_comb begin
    w_wbits_load = WbW'(WORD_W);
    if (w_remain < WORD_W) begin
      w_wbits_load = WbW'(w_remain);
    end
  end

  // State register with synchronous reset; reset aborts any load in flight.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state_q <= StIdle;
      r_shift_q <= '0;
      r_cnt_q   <= '0;
      r_wbits_q <= '0;
    end else begin
      r_state_q <= w_state_d;
      r_shift_q <= w_shift_d;
      r_cnt_q   <= w_cnt_d;
      r_wbits_q <= w_wbits_d;
    end
  end

  // Next-state logic: word handshake in StWait, bit serialization in StShift.
  always_comb begin
    w_state_d = r_state_q;
    w_shift_d = r_shift_q;
    w_cnt_d   = r_cnt_q;
    w_wbits_d = r_wbits_q;
    unique case (r_state_q)
      StIdle, StDone: begin
        if (start) begin
          w_state_d = StWait;
          w_cnt_d   = '0;
        end
      end
      StWait: begin
        if (cfg_valid) begin
          w_shift_d = cfg_word;
          w_wbits_d = w_wbits_load;
          w_state_d = StShift;
        end
      end
      StShift: begin
        w_shift_d = r_shift_q << 1;
        w_cnt_d   = r_cnt_q + CNT_W'(1);
        w_wbits_d = r_wbits_q - WbW'(1);
        if (r_wbits_q == WbW'(1)) begin
          w_state_d = ((32'(r_cnt_q) + 32'd1) == CHAIN_LEN) ? StDone : StWait;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Moore outputs; ccff_head is forced low whenever the chain is not shifting.
  always_comb begin
    cfg_ready      = 1'b0;
    chain_shift_en = 1'b0;
    ccff_head      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (r_state_q)
      StWait: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
      end
      StShift: begin
        chain_shift_en = 1'b1;
        ccff_head      = r_shift_q[WORD_W-1];
        busy           = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign bit_count = r_cnt_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: random word loads with a bit-level scoreboard,
// plus directed partial-word, stall, restart and reset scenarios.
module tb_ccff_chain_loader;

  localparam int unsigned CHAIN_LEN = 20;
  localparam int unsigned WORD_W    = 8;
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);

  logic              prog_clk = 1'b0;
  logic              prog_reset;
  logic              start;
  logic [WORD_W-1:0] cfg_word;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              chain_shift_en;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bit_count;

  ccff_chain_loader #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W)
  ) u_dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .cfg_word      (cfg_word),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .chain_shift_en(chain_shift_en),
    .busy          (busy),
    .done          (done),
    .bit_count     (bit_count)
  );

  always #5 prog_clk = ~prog_clk;

  int   n_vec   = 0;
  int   n_bad   = 0;
  int   cyc_cnt = 0;
  int   t_start = 0;
  int   mon_shifted = 0;  // bits the monitor has seen shifted since the last start
  int   remaining   = 0;  // bits the model still expects to accept from upstream
  bit   mon_en      = 1'b0;
  logic exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  initial forever begin
    @(posedge prog_clk);
    cyc_cnt++;
  end

  // Monitor: each shifting cycle pops one expected bit from the scoreboard.
  initial forever begin
    @(negedge prog_clk);
    if (mon_en) begin
      chk("bit_count", 32'(bit_count), 32'(mon_shifted));
      if (chain_shift_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_shift", 32'(chain_shift_en), 32'd0);
        end else begin
          chk("ccff_head", 32'(ccff_head), 32'(exp_q.pop_front()));
        end
        mon_shifted++;
      end else begin
        chk("ccff_head_idle", 32'(ccff_head), 32'd0);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge prog_clk);
    #1;
    start       = 1'b0;
    t_start     = cyc_cnt;
    exp_q.delete();
    mon_shifted = 0;
    remaining   = CHAIN_LEN;
    @(negedge prog_clk);
    chk("start_busy",  32'(busy),           32'd1);
    chk("start_done",  32'(done),           32'd0);
    chk("start_ready", 32'(cfg_ready),      32'd1);
    chk("start_shift", 32'(chain_shift_en), 32'd0);
  endtask

  // Offer one word after `stall` idle WAIT cycles; optionally pulse start
  // during the first shift cycle, which must be ignored.
  task automatic send_word(input logic [WORD_W-1:0] w, input int stall, input bit poke);
    int n;
    for (int i = 0; i < 100 && !cfg_ready; i++) @(negedge prog_clk);
    chk("ready_wait", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < stall; i++) begin
      chk("stall_ready", 32'(cfg_ready),      32'd1);
      chk("stall_shift", 32'(chain_shift_en), 32'd0);
      @(negedge prog_clk);
    end
    cfg_word  = w;
    cfg_valid = 1'b1;
    @(posedge prog_clk);
    n = (remaining < WORD_W) ? remaining : WORD_W;
    for (int i = 0; i < n; i++) exp_q.push_back(w[WORD_W-1-i]);
    remaining -= n;
    #1;
    cfg_valid = 1'b0;
    cfg_word  = $urandom;
    if (poke) begin
      start = 1'b1;
      @(posedge prog_clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic run_load(input bit directed, input int stall_max, input bit poke_en);
    logic [WORD_W-1:0] dir_words[3];
    int words;
    int stalls;
    int st;
    dir_words = '{8'hA5, 8'h3C, 8'hB7};
    words  = 0;
    stalls = 0;
    pulse_start();
    while (remaining > 0) begin
      st = $urandom_range(0, stall_max);
      send_word(directed ? dir_words[words] : WORD_W'($urandom), st,
                poke_en && ($urandom_range(0, 2) == 0));
      words++;
      stalls += st;
    end
    for (int i = 0; i < 4 * WORD_W && !done; i++) @(negedge prog_clk);
    chk("done",           32'(done),           32'd1);
    chk("done_busy",      32'(busy),           32'd0);
    chk("done_ready",     32'(cfg_ready),      32'd0);
    chk("done_count",     32'(bit_count),      CHAIN_LEN);
    chk("done_latency",   32'(cyc_cnt - t_start), 32'(CHAIN_LEN + words + stalls));
    chk("done_queue",     32'(exp_q.size()),   32'd0);
    // A pending word in DONE must not be accepted; count saturates.
    cfg_valid = 1'b1;
    repeat (3) begin
      @(negedge prog_clk);
      chk("hold_done",  32'(done),      32'd1);
      chk("hold_ready", 32'(cfg_ready), 32'd0);
      chk("hold_count", 32'(bit_count), CHAIN_LEN);
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    prog_reset = 1'b1;
    start      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_word   = '0;
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    chk("rst_ready", 32'(cfg_ready),      32'd0);
    chk("rst_head",  32'(ccff_head),      32'd0);
    chk("rst_shift", 32'(chain_shift_en), 32'd0);
    chk("rst_busy",  32'(busy),           32'd0);
    chk("rst_done",  32'(done),           32'd0);
    chk("rst_count", 32'(bit_count),      32'd0);
    prog_reset = 1'b0;
    mon_en     = 1'b1;
    @(negedge prog_clk);

    // Directed load: two full words then the top half of 0xB7.
    run_load(1'b1, 0, 1'b0);
    // Random loads restarted from DONE, with stalls and ignored start pulses.
    for (int k = 0; k < 6; k++) run_load(1'b0, (k % 2) ? 5 : 0, 1'b1);

    // Reset in the middle of shifting the first word.
    pulse_start();
    send_word(WORD_W'($urandom), 0, 1'b0);
    repeat (5) @(posedge prog_clk);
    #1;
    chk("pre_rst_count", 32'(bit_count), 32'd5);
    prog_reset = 1'b1;
    @(posedge prog_clk);
    #1;
    prog_reset  = 1'b0;
    exp_q.delete();
    mon_shifted = 0;
    cfg_valid   = 1'b1;
    repeat (4) begin
      @(negedge prog_clk);
      chk("mid_rst_ready", 32'(cfg_ready), 32'd0);
      chk("mid_rst_busy",  32'(busy),      32'd0);
      chk("mid_rst_done",  32'(done),      32'd0);
    end
    cfg_valid = 1'b0;

    // start coinciding with reset: reset wins, loader stays idle.
    start      = 1'b1;
    prog_reset = 1'b1;
    @(posedge prog_clk);
    #1;
    start      = 1'b0;
    prog_reset = 1'b0;
    repeat (2) begin
      @(negedge prog_clk);
      chk("rst_start_busy",  32'(busy),      32'd0);
      chk("rst_start_ready", 32'(cfg_ready), 32'd0);
    end

    run_load(1'b0, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus ever wedges.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain driver that sits directly upstream of the routing tiles' ccff_head input.
- Accepts configuration words over a valid/ready stream and serializes them MSB-first onto ccff_head, one bit per prog_clk cycle.
- Asserts chain_shift_en in exactly the cycles where ccff_head carries a valid bit; an external clock gate uses it so chain flops only shift on valid bits.
- Stops after exactly CHAIN_LEN bits and reports done.

Parameters:
- CHAIN_LEN, 64: total configuration bits in the downstream chain, >=1.
- WORD_W, 8: input word width, >=1.
- CNT_W, $clog2(CHAIN_LEN+1): width of bit_count.

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- prog_reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load.
- cfg_word  input  WORD_W  configuration word; bit WORD_W-1 is shifted first.
- cfg_valid  input  1  cfg_word valid.
- cfg_ready  output  1  loader accepts cfg_word this cycle.
- ccff_head  output  1  serial bit to the first chain element.
- chain_shift_en  output  1  chain shifts on the next prog_clk edge.
- busy  output  1  load in progress.
- done  output  1  CHAIN_LEN bits delivered; held until next start.
- bit_count  output  CNT_W  bits shifted since last start.

Behaviour:
- Interface: one clock, prog_clk; reset prog_reset is synchronous and active-high.
- Reset values: state=IDLE, cfg_ready=0, ccff_head=0, chain_shift_en=0, busy=0, done=0, bit_count=0. Reset mid-load aborts immediately; the chain keeps whatever bits were already shifted.
- State IDLE:
  - start=1 -> WAIT; clear bit_count and done; busy=1 from the next cycle.
- State WAIT:
  - cfg_ready=1 and chain_shift_en=0.
  - cfg_valid & cfg_ready latches cfg_word into the shift register, sets word_bits = min(WORD_W, CHAIN_LEN - bit_count), then -> SHIFT.
- State SHIFT:
  - cfg_ready=0, chain_shift_en=1, ccff_head = shift_reg[WORD_W-1].
  - Each cycle: shift_reg shifts left by one, bit_count increments, word_bits decrements.
  - When word_bits reaches 1 this cycle: if bit_count+1 == CHAIN_LEN -> DONE, else -> WAIT.
- State DONE:
  - done=1, busy=0, chain_shift_en=0, ccff_head=0.
  - start -> WAIT (restart); otherwise hold.
- Latency and throughput:
  - A word accepted at edge t drives its first bit on ccff_head at cycle t+1.
  - One idle WAIT cycle separates consecutive words, so a full word costs WORD_W+1 cycles.
- Final partial word: if CHAIN_LEN is not a multiple of WORD_W, only the upper (CHAIN_LEN mod WORD_W) bits of the last word are shifted; the low bits are discarded.
- Simultaneous and boundary conditions:
  - start while busy (WAIT/SHIFT) is ignored.
  - start in the same cycle as prog_reset: reset wins.
  - cfg_valid outside WAIT is not accepted; the word stays pending upstream.
  - cfg_valid held low in WAIT stalls indefinitely, with no shifting and no timeout.
- bit_count never exceeds CHAIN_LEN and saturates there in DONE.
- ccff_head is 0 whenever chain_shift_en=0.

Test Plan:
- Full-word load, CHAIN_LEN=16, WORD_W=8: start, then words 0xA5, 0x3C with valid always high -> ccff_head sequence 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; chain_shift_en high 16 cycles with one gap cycle; done=1 at cycle 18 after start; bit_count=16.
- Partial last word, CHAIN_LEN=2, WORD_W=8: word 0b10xxxxxx -> exactly two shift cycles, ccff_head 1 then 0; done; cfg_ready stays 0 afterwards.
- Upstream stall: cfg_valid low for 5 cycles in WAIT -> cfg_ready=1, chain_shift_en=0, bit_count frozen; resumes correctly when valid rises.
- start pulsed during SHIFT -> ignored: bit sequence and count are unchanged. start in DONE -> bit_count=0, done=0, new load proceeds.
- prog_reset asserted mid-SHIFT (bit_count=5) -> next cycle all outputs at reset values and state is IDLE; cfg_ready=0 until a new start.
- Back-to-back restart, CHAIN_LEN=64: two consecutive full loads -> each produces exactly 64 chain_shift_en cycles and 8 accepted handshakes.
